// File: rtl/reg_read_if.sv
// Operand-read port bundle: write-back port, decode issue request and registered operand outputs.
interface reg_read_if #(
  parameter int unsigned WIDTH = 32
) ();
  localparam int unsigned AW = 5;

  logic             regwr;
  logic [AW-1:0]    rw;
  logic [WIDTH-1:0] busW;
  logic [1:0]       fpoint;

  logic             id_valid;
  logic             id_ready;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic             rfp_a;
  logic             rfp_b;
  logic             id_regwr;
  logic [AW-1:0]    id_rw;
  logic             id_fp;
  logic             id_load;

  logic             q_valid;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;

  modport master (
    output regwr, rw, busW, fpoint,
    output id_valid, ra, rb, rfp_a, rfp_b, id_regwr, id_rw, id_fp, id_load,
    input  id_ready, q_valid, busA, busB
  );

  modport slave (
    input  regwr, rw, busW, fpoint,
    input  id_valid, ra, rb, rfp_a, rfp_b, id_regwr, id_rw, id_fp, id_load,
    output id_ready, q_valid, busA, busB
  );
endinterface

// File: rtl/reg_read.sv
// Operand-read stage: integer/FP register banks, load scoreboard and registered operand outputs.
// Optional same-cycle write-back forwarding is enabled by defining REG_READ_WB_BYPASS_EN.
module reg_read #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_read_if.slave  bus
);
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic [WIDTH-1:0] r_int_bank [NREG];
  logic [WIDTH-1:0] r_fp_bank  [NREG];
  logic [NREG-1:0]  r_pend_int;
  logic [NREG-1:0]  r_pend_fp;
  logic             r_q_valid;
  logic [WIDTH-1:0] r_bus_a;
  logic [WIDTH-1:0] r_bus_b;

  logic             w_wb_fp_sel;
  logic             w_wb_int;
  logic             w_wb_fp;
  logic             w_unused_fpoint_hi;

  logic             w_a_r0;
  logic             w_a_hit;
  logic             w_a_pend;
  logic             w_a_blk;
  logic [WIDTH-1:0] w_a_arr;
  logic [WIDTH-1:0] w_a_val;

  logic             w_b_r0;
  logic             w_b_hit;
  logic             w_b_pend;
  logic             w_b_blk;
  logic [WIDTH-1:0] w_b_arr;
  logic [WIDTH-1:0] w_b_val;

  logic             w_ready;
  logic             w_accept;
  logic             w_set_int;
  logic             w_set_fp;
  logic [NREG-1:0]  w_pend_int_nxt;
  logic [NREG-1:0]  w_pend_fp_nxt;

  // Write-back decode; integer r0 writes are dropped here so they never touch array or scoreboard
  assign w_wb_fp_sel        = bus.fpoint[0];
  assign w_unused_fpoint_hi = bus.fpoint[1];
  assign w_wb_int           = bus.regwr & ~w_wb_fp_sel & (bus.rw != AW'(0));
  assign w_wb_fp            = bus.regwr & w_wb_fp_sel;

  always_comb begin
    w_a_r0   = ~bus.rfp_a & (bus.ra == AW'(0));
    w_a_hit  = (bus.rfp_a ? w_wb_fp : w_wb_int) & (bus.rw == bus.ra);
    w_a_pend = bus.rfp_a ? r_pend_fp[bus.ra] : r_pend_int[bus.ra];
    w_a_arr  = bus.rfp_a ? r_fp_bank[bus.ra] : r_int_bank[bus.ra];
`ifdef REG_READ_WB_BYPASS_EN
    w_a_blk  = w_a_pend & ~w_a_hit;
    w_a_val  = w_a_r0 ? '0 : (w_a_hit ? bus.busW : w_a_arr);
`else
    // Without forwarding a same-cycle write-back target must wait for the array update
    w_a_blk  = w_a_pend | w_a_hit;
    w_a_val  = w_a_r0 ? '0 : w_a_arr;
`endif
  end

  always_comb begin
    w_b_r0   = ~bus.rfp_b & (bus.rb == AW'(0));
    w_b_hit  = (bus.rfp_b ? w_wb_fp : w_wb_int) & (bus.rw == bus.rb);
    w_b_pend = bus.rfp_b ? r_pend_fp[bus.rb] : r_pend_int[bus.rb];
    w_b_arr  = bus.rfp_b ? r_fp_bank[bus.rb] : r_int_bank[bus.rb];
`ifdef REG_READ_WB_BYPASS_EN
    w_b_blk  = w_b_pend & ~w_b_hit;
    w_b_val  = w_b_r0 ? '0 : (w_b_hit ? bus.busW : w_b_arr);
`else
    w_b_blk  = w_b_pend | w_b_hit;
    w_b_val  = w_b_r0 ? '0 : w_b_arr;
`endif
  end

  assign w_ready   = ~(w_a_blk | w_b_blk);
  assign w_accept  = bus.id_valid & w_ready;
  assign w_set_int = w_accept & bus.id_regwr & bus.id_load & ~bus.id_fp & (bus.id_rw != AW'(0));
  assign w_set_fp  = w_accept & bus.id_regwr & bus.id_load & bus.id_fp;

  // Scoreboard next state: clear on write-back first, so a same-cycle new load wins
  always_comb begin
    w_pend_int_nxt = r_pend_int;
    w_pend_fp_nxt  = r_pend_fp;
    if (w_wb_int) w_pend_int_nxt[bus.rw] = 1'b0;
    if (w_wb_fp)  w_pend_fp_nxt[bus.rw]  = 1'b0;
    if (w_set_int) w_pend_int_nxt[bus.id_rw] = 1'b1;
    if (w_set_fp)  w_pend_fp_nxt[bus.id_rw]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_int <= '0;
      r_pend_fp  <= '0;
    end else begin
      r_pend_int <= w_pend_int_nxt;
      r_pend_fp  <= w_pend_fp_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_int_bank[i] <= '0;
        r_fp_bank[i]  <= '0;
      end
    end else begin
      if (w_wb_int) r_int_bank[bus.rw] <= bus.busW;
      if (w_wb_fp)  r_fp_bank[bus.rw]  <= bus.busW;
    end
  end

  // Operand register: valid pulses only on accept, data holds through bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_valid <= 1'b0;
      r_bus_a   <= '0;
      r_bus_b   <= '0;
    end else begin
      r_q_valid <= w_accept;
      if (w_accept) begin
        r_bus_a <= w_a_val;
        r_bus_b <= w_b_val;
      end
    end
  end

  assign bus.id_ready = w_ready;
  assign bus.q_valid  = r_q_valid;
  assign bus.busA     = r_bus_a;
  assign bus.busB     = r_bus_b;
endmodule

// File: tb/tb_reg_read.sv
// Bench for reg_read: directed vector table, random traffic against a register-file model, reset cases.
module tb_reg_read;
  localparam int unsigned W = 32;

`ifdef REG_READ_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_read_if #(.WIDTH(W)) bus ();
  reg_read #(.WIDTH(W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic        fpw;
    logic        vld;
    logic [4:0]  ra;
    logic        fa;
    logic [4:0]  rb;
    logic        fb;
    logic        idw;
    logic [4:0]  idrw;
    logic        idfp;
    logic        idld;
    logic        er;
    logic        eq;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_int [32];
  logic [31:0] m_fp  [32];
  bit          m_pend_int [32];
  bit          m_pend_fp  [32];
  logic        m_qv;
  logic [31:0] m_a;
  logic [31:0] m_b;

  function automatic vec_t mk(logic regwr, logic [4:0] rw, logic [31:0] busw, logic fpw,
                              logic vld, logic [4:0] ra, logic fa, logic [4:0] rb, logic fb,
                              logic idw, logic [4:0] idrw, logic idfp, logic idld,
                              logic er, logic eq, logic [31:0] ea, logic [31:0] eb);
    vec_t v;
    v.regwr = regwr; v.rw = rw; v.busw = busw; v.fpw = fpw;
    v.vld = vld; v.ra = ra; v.fa = fa; v.rb = rb; v.fb = fb;
    v.idw = idw; v.idrw = idrw; v.idfp = idfp; v.idld = idld;
    v.er = er; v.eq = eq; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_int[i] = '0; m_fp[i] = '0; m_pend_int[i] = 0; m_pend_fp[i] = 0;
    end
    m_qv = 1'b0; m_a = '0; m_b = '0;
  endtask

  function automatic bit is_zero_reg(logic [4:0] idx, logic fp);
    return (fp == 1'b0) && (idx == 5'd0);
  endfunction

  function automatic bit m_wb_hits(vec_t v, logic [4:0] idx, logic fp);
    return v.regwr && (v.fpw == fp) && (v.rw == idx) && !is_zero_reg(idx, fp);
  endfunction

  function automatic bit m_blocked(vec_t v, logic [4:0] idx, logic fp);
    bit pend;
    if (is_zero_reg(idx, fp)) return 0;
    pend = fp ? m_pend_fp[idx] : m_pend_int[idx];
    if (BYPASS) return pend && !m_wb_hits(v, idx, fp);
    return pend || m_wb_hits(v, idx, fp);
  endfunction

  function automatic logic [31:0] m_read(vec_t v, logic [4:0] idx, logic fp);
    if (is_zero_reg(idx, fp)) return '0;
    if (BYPASS && m_wb_hits(v, idx, fp)) return v.busw;
    return fp ? m_fp[idx] : m_int[idx];
  endfunction

  function automatic bit m_ready(vec_t v);
    return !(m_blocked(v, v.ra, v.fa) || m_blocked(v, v.rb, v.fb));
  endfunction

  // Advance the model by one clock edge for the inputs in v
  task automatic m_clock(vec_t v, bit acc);
    logic [31:0] va, vb;
    va = m_read(v, v.ra, v.fa);
    vb = m_read(v, v.rb, v.fb);
    m_qv = acc;
    if (acc) begin m_a = va; m_b = vb; end
    if (v.regwr) begin
      if (v.fpw) begin m_fp[v.rw] = v.busw; m_pend_fp[v.rw] = 0; end
      else if (v.rw != 5'd0) begin m_int[v.rw] = v.busw; m_pend_int[v.rw] = 0; end
    end
    if (acc && v.idw && v.idld) begin
      if (v.idfp) m_pend_fp[v.idrw] = 1;
      else if (v.idrw != 5'd0) m_pend_int[v.idrw] = 1;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(vec_t v);
    bus.regwr    = v.regwr;
    bus.rw       = v.rw;
    bus.busW     = v.busw;
    bus.fpoint   = {1'($urandom_range(1, 0)), v.fpw};
    bus.id_valid = v.vld;
    bus.ra       = v.ra;
    bus.rfp_a    = v.fa;
    bus.rb       = v.rb;
    bus.rfp_b    = v.fb;
    bus.id_regwr = v.idw;
    bus.id_rw    = v.idrw;
    bus.id_fp    = v.idfp;
    bus.id_load  = v.idld;
  endtask

  // One cycle: drive, check id_ready, clock, check operand register
  task automatic step(string tag, vec_t v, bit use_tab);
    bit er, acc;
    drive(v);
    #1;
    er  = m_ready(v);
    acc = v.vld && er;
    chk({tag, ".id_ready"}, 32'(bus.id_ready), use_tab ? 32'(v.er) : 32'(er));
    m_clock(v, acc);
    @(posedge clk);
    #1;
    chk({tag, ".q_valid"}, 32'(bus.q_valid), use_tab ? 32'(v.eq) : 32'(m_qv));
    chk({tag, ".busA"}, bus.busA, use_tab ? v.ea : m_a);
    chk({tag, ".busB"}, bus.busB, use_tab ? v.eb : m_b);
  endtask

  vec_t tab[$];
  vec_t v;

  initial begin
    // Reset with a request pending
    m_reset();
    v = mk(0, 0, 0, 0, 1, 5, 0, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(v);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.q_valid", 32'(bus.q_valid), 32'd0);
    chk("rst.busA", bus.busA, 32'd0);
    chk("rst.busB", bus.busB, 32'd0);
    chk("rst.id_ready", 32'(bus.id_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tab.push_back(mk(0, 0, 0, 0, 1, 5, 0, 6, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tab.push_back(mk(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 7, 0, 7, 1, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0));
    tab.push_back(mk(1, 2, 32'h11112222, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 2, 1, 7, 0, 0, 0, 0, 0, 1, 1, 32'h11112222, 32'hDEADBEEF));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 1, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (BYPASS) tab.push_back(mk(1, 3, 32'h55, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h55, 0));
    else        tab.push_back(mk(1, 3, 32'h55, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h55, 0));
    tab.push_back(mk(1, 0, 32'h1234, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    if (BYPASS) tab.push_back(mk(1, 0, 32'h1234, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234, 0));
    else        tab.push_back(mk(1, 0, 32'h1234, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0, 1, 1, 1, 0, 0));
    tab.push_back(mk(1, 4, 32'h77, 0, 1, 0, 0, 0, 0, 1, 4, 0, 1, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (BYPASS) tab.push_back(mk(1, 4, 32'h88, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h88, 0));
    else        tab.push_back(mk(1, 4, 32'h88, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h88, 0));
    if (BYPASS) tab.push_back(mk(1, 9, 32'hA5, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA5, 0));
    else        tab.push_back(mk(1, 9, 32'hA5, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h88, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA5, 0));
    if (BYPASS) tab.push_back(mk(1, 5, 32'hCAFE, 1, 1, 7, 0, 5, 1, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 32'hCAFE));
    else        tab.push_back(mk(1, 5, 32'hCAFE, 1, 1, 7, 0, 5, 1, 0, 0, 0, 0, 0, 0, 32'hA5, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 7, 0, 5, 1, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 32'hCAFE));

    foreach (tab[i]) step($sformatf("tab%0d", i), tab[i], 1'b1);

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      v = mk(1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom, 1'($urandom_range(1, 0)),
             1'($urandom_range(3, 0) != 0), 5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
             5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
             1'($urandom_range(3, 0) == 0), 0, 0, 0, 0);
      step($sformatf("rnd%0d", i), v, 1'b0);
    end

    // Reset while stalled on a load discards the pending bit
    step("ms.load", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 10, 0, 1, 0, 0, 0, 0), 1'b0);
    step("ms.stall", mk(0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    rst_n = 1'b0;
    m_reset();
    #2;
    chk("ms.rst.q_valid", 32'(bus.q_valid), 32'd0);
    chk("ms.rst.busA", bus.busA, 32'd0);
    chk("ms.rst.id_ready", 32'(bus.id_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("ms.issue", mk(0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/reg_read.md
# reg_read

Operand-read stage for the integer and floating-point register files; the read-side counterpart to the pipeline's write-back stage. Holds both 32-entry register banks, accepts the write-back port (`regwr`, `rw`, `busW`, `fpoint`), and serves two read operands to the execute stage through a registered output with write-back bypass. A per-register pending scoreboard tracks outstanding load destinations and stalls issue on load-use hazards.

## Interface
- `WIDTH`, 32: data width of each register.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `regwr` in 1: write-back enable.
- `rw` in 5: write-back destination register.
- `busW` in WIDTH: write-back data.
- `fpoint` in 2: write-back bank select. `fpoint[0]`=1 selects the FP bank. `fpoint[1]` is ignored.
- `id_valid` in 1: decode presents an instruction.
- `id_ready` out 1: instruction accepted this cycle. Combinational; low means stall.
- `ra`, `rb` in 5 each: source register indices.
- `rfp_a`, `rfp_b` in 1 each: source bank (1 = FP).
- `id_regwr` in 1: the issuing instruction writes a register.
- `id_rw` in 5, `id_fp` in 1: destination index and bank of the issuing instruction.
- `id_load` in 1: the destination is produced late (load). Sets the pending bit.
- `q_valid` out 1: registered operands are valid.
- `busA`, `busB` out WIDTH: registered operand values.

## Operation
- Banks:
  - Integer bank register 0 always reads 0; writes to it are discarded and never set its pending bit.
  - FP register 0 is an ordinary register.
- Write: on a clock edge with `regwr`=1, `busW` is written to bank `fpoint[0]`, entry `rw`.
- Read of source X (bank b):
  - Integer r0 returns 0.
  - Else, with bypass enabled (see Configuration), if `regwr` & `rw`==X & `fpoint[0]`==b this cycle, return `busW`.
  - Otherwise return the array value.
- Hazard: a source is blocked if its pending bit is set and it is not being written back this cycle.
  - `id_ready` = !(blocked(ra) | blocked(rb)).
  - Without bypass, a source equal to the current write-back target is also blocked.
- Accept = `id_valid` & `id_ready`.
- Scoreboard, one bit per register per bank:
  - Set on accept when `id_regwr` & `id_load`.
  - Cleared on write-back to that register.
  - If set and clear hit the same register in the same cycle, set wins (a newer load owns the register).
- Output register:
  - On accept: `q_valid`←1, `busA`/`busB`←resolved operands.
  - Otherwise: `q_valid`←0 and `busA`/`busB` hold their values.
- Reset (asynchronous, `rst_n`=0):
  - Both banks cleared to 0.
  - Scoreboard cleared.
  - `q_valid`=0, `busA`=0, `busB`=0.
  - `id_ready` evaluates to `id_valid`-independent 1 (no pending bits).
- Reset mid-stall discards all pending state; the first instruction after release issues immediately.

## Timing
- Read latency is one cycle: operands accepted in cycle N appear on `busA`/`busB` with `q_valid`=1 in cycle N+1.
- `id_ready` is combinational from `ra`, `rb`, the banks, the scoreboard and the write-back port; there is no registered stall.
- A stall inserts exactly one bubble (`q_valid`=0) per stalled cycle.
- With bypass, a load-use stall lasts until the cycle the load's write-back is present. Issue proceeds in that same cycle with the bypassed value.
- Write-back and read of the same register in one cycle:
  - With bypass, the new value is returned.
  - Without bypass, issue stalls one cycle and the array value is read on the next cycle.

## Configuration
- `REG_READ_WB_BYPASS_EN` defined: same-cycle write-back data is forwarded to both read ports, and no hazard is raised for a source matching the current write-back.
- Not defined: no forwarding. Any source matching the active write-back target (same bank and index, excluding integer r0) deasserts `id_ready` for that cycle, and the value is read from the array on the next cycle. Pending-bit behaviour is unchanged.

## Test plan
- **Reset:** hold `rst_n`=0 with `id_valid`=1 → `q_valid`=0, `busA`=`busB`=0. Release, then issue `ra`=5, `rb`=6 → next cycle `q_valid`=1, `busA`=`busB`=0.
- **Write then read:** write int r7=32'hDEADBEEF, then issue `ra`=7 (int) and `rb`=7 (`rfp_b`=1) → `busA`=32'hDEADBEEF, `busB`=0 (FP f7 untouched).
- **Integer r0:** write-back to int r0 with 32'h1234 alongside `ra`=0 → `busA`=0, no stall; same test on FP f0 → `busA`=32'h1234 (bypass build).
- **Load-use:** issue load to r3 (`id_load`=1). Issue `ra`=3 → `id_ready`=0 and `q_valid`=0 for 2 cycles. Write-back r3=32'h55 → issue accepted that cycle, `busA`=32'h55 next cycle.
- **Simultaneous set/clear:** write-back r4 in the same cycle as accepting a new load to r4 → r4 remains pending, and a following read of r4 stalls.
- **No-bypass build:** write-back r9=32'hA5 with `ra`=9 → `id_ready`=0 for one cycle, then accept with `busA`=32'hA5.
